// File: rtl/agc_gain_loop.sv
// EMA-smoothed magnitude compared against a reference level; the scaled error is
// integrated into a saturating gain word. Three pipeline stages, one sample per clock.
module agc_gain_loop #(
    parameter int W_MAG   = 16,
    parameter int W_A     = 16,
    parameter int F_A     = 14,
    parameter int W_ALPHA = 16,
    parameter int F_ALPHA = 14,
    parameter int W_GAIN  = 16,
    parameter int F_GAIN  = 14,
    parameter int G_INIT  = 16384,
    parameter int G_MIN   = 64,
    parameter int G_MAX   = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W_MAG-1:0]   s_mag_data,
    input  logic               s_mag_valid,
    input  logic [W_A-1:0]     i_a,
    input  logic [W_ALPHA-1:0] i_alpha,
    input  logic [W_MAG-1:0]   i_reference,
    input  logic               i_freeze,
    output logic [W_GAIN-1:0]  m_gain,
    output logic               m_gain_valid,
    output logic [W_MAG-1:0]   m_level,
    output logic               o_sat_hi,
    output logic               o_sat_lo
);
    localparam int W_DIFF = W_MAG + 1;
    localparam int W_PA   = W_A + 1 + W_DIFF;
    localparam int W_PG   = W_ALPHA + 1 + W_DIFF;
    localparam int W_SUM  = ((W_PG > W_GAIN) ? W_PG : W_GAIN + 1) + 1;

    localparam logic [W_A-1:0]          A_ONE   = W_A'(2 ** F_A);
    localparam logic signed [W_SUM-1:0] G_MIN_S = W_SUM'(G_MIN);
    localparam logic signed [W_SUM-1:0] G_MAX_S = W_SUM'(G_MAX);

    logic [W_MAG-1:0]         level_q, level_d;
    logic                     v1_q, v1_d;
    logic signed [W_DIFF-1:0] err_q, err_d;
    logic                     v2_q, v2_d;
    logic [W_GAIN-1:0]        gain_q, gain_d;
    logic                     gain_valid_q, gain_valid_d;
    logic                     sat_hi_q, sat_hi_d;
    logic                     sat_lo_q, sat_lo_d;

    logic [W_A-1:0]           a_eff;
    logic signed [W_DIFF-1:0] diff;
    logic signed [W_PA-1:0]   a_ext, diff_ext, a_prod, a_step, level_sum;
    logic signed [W_PG-1:0]   alpha_ext, err_ext, delta;
    logic signed [W_SUM-1:0]  gain_ext, delta_ext, sum;

    // Stage 1: EMA level update (a_eff never exceeds 1.0, the clamp is a backstop)
    always_comb begin
        a_eff     = (i_a > A_ONE) ? A_ONE : i_a;
        diff      = $signed({1'b0, s_mag_data}) - $signed({1'b0, level_q});
        a_ext     = $signed({{(W_PA - W_A){1'b0}}, a_eff});
        diff_ext  = {{(W_PA - W_DIFF){diff[W_DIFF-1]}}, diff};
        a_prod    = a_ext * diff_ext;
        a_step    = a_prod >>> F_A;
        level_sum = $signed({{(W_PA - W_MAG){1'b0}}, level_q}) + a_step;
        level_d   = level_q;
        v1_d      = s_mag_valid;
        if (s_mag_valid) begin
            if (level_sum[W_PA-1])
                level_d = '0;
            else if (|level_sum[W_PA-2:W_MAG])
                level_d = '1;
            else
                level_d = level_sum[W_MAG-1:0];
        end
    end

    // Stage 2: level error against the reference
    always_comb begin
        err_d = err_q;
        v2_d  = v1_q;
        if (v1_q)
            err_d = $signed({1'b0, i_reference}) - $signed({1'b0, level_q});
    end

    // Stage 3: integrate the scaled error into the clamped gain word
    always_comb begin
        alpha_ext    = $signed({{(W_PG - W_ALPHA){1'b0}}, i_alpha});
        err_ext      = {{(W_PG - W_DIFF){err_q[W_DIFF-1]}}, err_q};
        delta        = (alpha_ext * err_ext) >>> F_ALPHA;
        delta_ext    = {{(W_SUM - W_PG){delta[W_PG-1]}}, delta};
        gain_ext     = $signed({{(W_SUM - W_GAIN){1'b0}}, gain_q});
        sum          = gain_ext + delta_ext;
        gain_d       = gain_q;
        sat_hi_d     = sat_hi_q;
        sat_lo_d     = sat_lo_q;
        gain_valid_d = v2_q;
        if (v2_q && !i_freeze) begin
            sat_hi_d = (sum > G_MAX_S);
            sat_lo_d = (sum < G_MIN_S);
            if (sum > G_MAX_S)
                gain_d = W_GAIN'(G_MAX);
            else if (sum < G_MIN_S)
                gain_d = W_GAIN'(G_MIN);
            else
                gain_d = sum[W_GAIN-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q      <= '0;
            v1_q         <= 1'b0;
            err_q        <= '0;
            v2_q         <= 1'b0;
            gain_q       <= W_GAIN'(G_INIT);
            gain_valid_q <= 1'b0;
            sat_hi_q     <= 1'b0;
            sat_lo_q     <= 1'b0;
        end else begin
            level_q      <= level_d;
            v1_q         <= v1_d;
            err_q        <= err_d;
            v2_q         <= v2_d;
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
            sat_hi_q     <= sat_hi_d;
            sat_lo_q     <= sat_lo_d;
        end
    end

    assign m_gain       = gain_q;
    assign m_gain_valid = gain_valid_q;
    assign m_level      = level_q;
    assign o_sat_hi     = sat_hi_q;
    assign o_sat_lo     = sat_lo_q;
endmodule

// File: tb/tb_agc_gain_loop.sv
// Bench for agc_gain_loop: event-queue reference model checked every cycle,
// plus hand-computed directed expectations.
module tb_agc_gain_loop;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_mag_data = '0;
    logic        s_mag_valid = 1'b0;
    logic [15:0] i_a = '0;
    logic [15:0] i_alpha = '0;
    logic [15:0] i_reference = '0;
    logic        i_freeze = 1'b0;
    logic [15:0] m_gain;
    logic        m_gain_valid;
    logic [15:0] m_level;
    logic        o_sat_hi;
    logic        o_sat_lo;

    int n_cmp = 0;
    int n_err = 0;

    agc_gain_loop dut (
        .clk(clk), .reset(reset),
        .s_mag_data(s_mag_data), .s_mag_valid(s_mag_valid),
        .i_a(i_a), .i_alpha(i_alpha), .i_reference(i_reference), .i_freeze(i_freeze),
        .m_gain(m_gain), .m_gain_valid(m_gain_valid), .m_level(m_level),
        .o_sat_hi(o_sat_hi), .o_sat_lo(o_sat_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Reference model: each accepted sample schedules its error calculation one
    // cycle later and its gain update two cycles later, using the controls seen then.
    typedef struct { longint v; longint due; } ev_t;
    ev_t    lq[$];
    ev_t    eq[$];
    longint cyc = 0;
    longint md_lvl = 0, md_gain = 16384;
    bit     md_hi = 0, md_lo = 0, md_vld = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_lvl = 0; md_gain = 16384; md_hi = 0; md_lo = 0; md_vld = 0;
            lq.delete(); eq.delete();
        end else begin
            longint aeff, sum;
            cyc++;
            md_vld = 0;
            if (eq.size() > 0 && eq[0].due == cyc) begin
                sum = md_gain + fdiv(longint'(i_alpha) * eq[0].v, 16384);
                if (!i_freeze) begin
                    md_gain = clampl(sum, 64, 65535);
                    md_hi = (sum > 65535);
                    md_lo = (sum < 64);
                end
                md_vld = 1;
                void'(eq.pop_front());
            end
            if (lq.size() > 0 && lq[0].due == cyc) begin
                eq.push_back('{v: longint'(i_reference) - lq[0].v, due: cyc + 1});
                void'(lq.pop_front());
            end
            if (s_mag_valid) begin
                aeff = (i_a > 16384) ? 16384 : longint'(i_a);
                md_lvl = clampl(md_lvl + fdiv(aeff * (longint'(s_mag_data) - md_lvl), 16384), 0, 65535);
                lq.push_back('{v: md_lvl, due: cyc + 1});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mdl_level", m_level, md_lvl);
            chk("mdl_gain", m_gain, md_gain);
            chk("mdl_valid", m_gain_valid, md_vld);
            chk("mdl_sat_hi", o_sat_hi, md_hi);
            chk("mdl_sat_lo", o_sat_lo, md_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input int a, input int al, input int rf, input bit fz, input bit v);
        @(posedge clk);
        #3 reset = 1'b1;
        s_mag_data = 16'(d); i_a = 16'(a); i_alpha = 16'(al);
        i_reference = 16'(rf); i_freeze = fz; s_mag_valid = v;
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        // Scenario 1: basic convergence
        start(1000, 8192, 16384, 1000, 0, 1);
        step; chk("t1_lvl1", m_level, 500); chk("t1_vld_e1", m_gain_valid, 0);
        step; chk("t1_lvl2", m_level, 750); chk("t1_vld_e2", m_gain_valid, 0);
        step; chk("t1_lvl3", m_level, 875); chk("t1_g1", m_gain, 16884); chk("t1_vld_e3", m_gain_valid, 1);
        step; chk("t1_lvl4", m_level, 937); chk("t1_g2", m_gain, 17134);
        s_mag_valid = 1'b0;
        step; chk("t1_g3", m_gain, 17259);
        step; chk("t1_g4", m_gain, 17322); chk("t1_vld_e6", m_gain_valid, 1);
        chk("t1_hi", o_sat_hi, 0); chk("t1_lo", o_sat_lo, 0);
        step; chk("t1_vld_e7", m_gain_valid, 0); chk("t1_lvl_hold", m_level, 937);

        // Scenario 4: freeze the gain for samples 2 and 3
        start(1000, 8192, 16384, 1000, 0, 1);
        step;
        step; chk("t4_lvl2", m_level, 750);
        step; chk("t4_lvl3", m_level, 875); chk("t4_g1", m_gain, 16884);
        i_freeze = 1'b1;
        step; chk("t4_g2", m_gain, 16884); chk("t4_vld2", m_gain_valid, 1);
        s_mag_valid = 1'b0;
        step; chk("t4_g3", m_gain, 16884); chk("t4_vld3", m_gain_valid, 1);
        i_freeze = 1'b0;
        step; chk("t4_g4", m_gain, 16947);

        // Scenario 2: upper clamp, then scenario 6: async reset with samples in flight
        start(0, 16384, 32767, 30000, 0, 1);
        step; step;
        step; chk("t2_g", m_gain, 65535); chk("t2_hi", o_sat_hi, 1); chk("t2_lo", o_sat_lo, 0);
        step; chk("t2_g_hold", m_gain, 65535); chk("t2_hi_hold", o_sat_hi, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_lvl", m_level, 0); chk("t6_gain", m_gain, 16384); chk("t6_vld", m_gain_valid, 0);
        chk("t6_hi", o_sat_hi, 0); chk("t6_lo", o_sat_lo, 0);
        s_mag_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step; chk("t6_no_pulse", m_gain_valid, 0); chk("t6_gain_hold", m_gain, 16384);
        end

        // Scenario 3: lower clamp, then alpha = 0 clears the flag without moving gain
        start(30000, 16384, 16384, 0, 0, 1);
        step; chk("t3_lvl", m_level, 30000);
        step;
        step; chk("t3_g", m_gain, 64); chk("t3_lo", o_sat_lo, 1); chk("t3_hi", o_sat_hi, 0);
        i_alpha = '0; s_mag_valid = 1'b0;
        step; chk("t3_a0_g", m_gain, 64); chk("t3_a0_lo", o_sat_lo, 0);

        // Scenario 5: alternate-cycle samples with i_a above 1.0
        start(0, 20000, 3000, 20000, 0, 0);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] d;
            d = 16'($urandom_range(0, 65535));
            s_mag_valid = (i % 2 == 0);
            s_mag_data = d;
            step;
            if (i % 2 == 0) chk("t5_level_eq_sample", m_level, d);
        end

        // Randomized run against the model
        start(0, 4000, 8000, 12000, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            s_mag_valid = ($urandom_range(0, 3) != 0);
            s_mag_data = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: i_a = '0;
                    1: i_a = 16'($urandom_range(16384, 65535));
                    default: i_a = 16'($urandom_range(0, 16384));
                endcase
                i_alpha = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
                i_reference = 16'($urandom_range(0, 65535));
            end
            i_freeze = ($urandom_range(0, 9) == 0);
            step;
        end
        s_mag_valid = 1'b0;
        i_freeze = 1'b0;
        step; step; step; step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
